program_end_monitor: RTL
========================

// Module: program_end_monitor
// PURPOSE
//  Successor to the single-threshold end-of-program flag. Watches the IF/ID instruction word.
//  Declares program end after END_RUN consecutive valid end-marker words, then a drain delay.
//  Also reports execution statistics (cycles, retired-fetch count) to the debug unit.
//  Sits beside the IF/ID register; outputs feed the debug/UART controller.
// PARAMETERS
//  DATA_W        32      instruction width
//  END_WORD      32'h0   end-marker encoding; default 0 = sll $0,$0,0 (NOP)
//  END_RUN       4       consecutive valid END_WORDs required (1..255)
//  DRAIN_CYCLES  3       extra cycles after run detect, so in-flight instrs reach WB (0..255)
//  CNT_W         32      width of cycle_count / instr_count
//  TIMEOUT       1000000 watchdog limit in cycles (used only with PROGRAM_END_WATCHDOG_EN)
// PORTS
//  pipeClk                input   1       pipeline clock
//  reset                  input   1       synchronous, active-high
//  instruction_IFID       input   DATA_W  instruction currently in IF/ID
//  instr_valid            input   1       IF/ID loaded a new instr this cycle (0 = stall/bubble)
//  clear_program_finished input   1       sync clear from debug unit; same effect as reset
//  programEnd             output  1       registered, sticky end flag
//  end_cause              output  2       00 none, 01 end-marker run, 10 watchdog timeout
//  run_len                output  8       current consecutive END_WORD count, saturates at END_RUN
//  cycle_count            output  CNT_W   cycles since reset/clear
//  instr_count            output  CNT_W   valid non-END_WORD instrs seen
// BEHAVIOUR
//  - Reset or clear (either high at posedge):
//    - state=RUN, programEnd=0, end_cause=00, run_len=0, counts=0, drain counter=0.
//    - Clear/reset beats every other event in that cycle; that cycle's instr is not counted.
//  - FSM RUN -> DRAIN -> ENDED. ENDED exits only via reset/clear.
//  - RUN, instr_valid=1, instr==END_WORD: run_len++, saturating at END_RUN.
//  - RUN, instr_valid=1, instr!=END_WORD: run_len=0, instr_count++.
//  - RUN, instr_valid=0: run_len and instr_count hold; stalls neither break nor extend a run.
//  - Edge sampling the END_RUN-th match:
//    - DRAIN_CYCLES=0: go to ENDED, so programEnd=1 right after that edge.
//    - Otherwise: go to DRAIN, load drain counter=DRAIN_CYCLES.
//  - DRAIN: decrement every cycle regardless of instr inputs; at 1 -> ENDED.
//    programEnd rises exactly DRAIN_CYCLES edges after the detecting edge.
//  - Entering ENDED sets end_cause=01, unless the watchdog caused it.
//  - programEnd = (state==ENDED), registered; no combinational path from inputs.
//  - cycle_count: ++ each cycle in RUN and DRAIN; frozen in ENDED; saturates at all-ones.
//  - instr_count: only changes in RUN; saturates at all-ones.
//  - END_RUN=1: a single valid END_WORD triggers detection.
// CONFIGURATION
//  PROGRAM_END_WATCHDOG_EN defined:
//    - In RUN, when cycle_count == TIMEOUT-1 at an edge: go straight to ENDED, end_cause=10.
//    - Same edge also completes a run: marker run wins, end_cause=01.
//    - Watchdog never fires in DRAIN.
//  Not defined: no watchdog logic; TIMEOUT ignored; end_cause is only 00 or 01.
// TESTING
//  1. DRAIN_CYCLES=0: reset, then 4 valid 0x0 words -> programEnd=1 after 4th edge, end_cause=01.
//  2. 3 zeros, 0x20080005, 4 zeros (DRAIN=0) -> run_len 3 then 0; end only after last zero;
//     instr_count=1.
//  3. zeros interleaved with instr_valid=0 cycles -> run_len holds; end after 4th valid zero.
//  4. DRAIN_CYCLES=3, run done, clear at drain cycle 2 -> programEnd stays 0; counts=0;
//     new run ends normally.
//  5. After end: cycle_count frozen for 10 more cycles; reset -> programEnd=0 next edge.
//  6. WATCHDOG_EN, TIMEOUT=20, no zeros -> programEnd=1 after edge 20, end_cause=10;
//     without macro -> stays 0.

Source files
------------

// File: rtl/program_end_monitor.sv
// program_end_monitor: watches the IF/ID instruction word and declares program end after
// END_RUN consecutive valid end-marker words plus a DRAIN_CYCLES drain delay. Also keeps
// cycle and retired-fetch counters for the debug unit.
// Optional feature: define PROGRAM_END_WATCHDOG_EN to end the program after TIMEOUT cycles
// spent in RUN (end_cause = 10).

module program_end_monitor #(
   parameter int unsigned       DATA_W       = 32,
   parameter logic [DATA_W-1:0] END_WORD     = '0,
   parameter int unsigned       END_RUN      = 4,
   parameter int unsigned       DRAIN_CYCLES = 3,
   parameter int unsigned       CNT_W        = 32,
   parameter int unsigned       TIMEOUT      = 1000000
) (
   input  logic              pipeClk,
   input  logic              reset,
   input  logic [DATA_W-1:0] instruction_IFID,
   input  logic              instr_valid,
   input  logic              clear_program_finished,
   output logic              programEnd,
   output logic [1:0]        end_cause,
   output logic [7:0]        run_len,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  instr_count
);

   typedef enum logic [1:0] {StRun, StDrain, StEnded} state_t;

   state_t     state;
   logic [7:0] drain_cnt;
   logic       is_end_word;
   logic       run_done;
   logic       cycle_sat;
   logic       instr_sat;

   assign is_end_word = (instruction_IFID == END_WORD);
   // This edge samples the END_RUN-th consecutive valid marker.
   assign run_done    = instr_valid && is_end_word && (run_len == 8'(END_RUN - 1));
   assign cycle_sat   = &cycle_count;
   assign instr_sat   = &instr_count;

`ifdef PROGRAM_END_WATCHDOG_EN
   logic wd_hit;
   // Compare in a wide domain so a narrow CNT_W never aliases onto TIMEOUT-1.
   assign wd_hit = (64'(cycle_count) == (64'(TIMEOUT) - 64'd1));
`endif

   // FSM plus counters; every output is a register.
   always_ff @(posedge pipeClk) begin
      if (reset || clear_program_finished) begin
         state       <= StRun;
         programEnd  <= 1'b0;
         end_cause   <= 2'b00;
         run_len     <= '0;
         cycle_count <= '0;
         instr_count <= '0;
         drain_cnt   <= '0;
      end else begin
         case (state)
            StRun: begin
               if (!cycle_sat) cycle_count <= cycle_count + CNT_W'(1);
               // Stalls (instr_valid=0) neither break nor extend a run.
               if (instr_valid) begin
                  if (is_end_word) begin
                     if (run_len != 8'(END_RUN)) run_len <= run_len + 8'd1;
                  end else begin
                     run_len <= '0;
                     if (!instr_sat) instr_count <= instr_count + CNT_W'(1);
                  end
               end
               // A completed marker run takes priority over a coincident watchdog hit.
               if (run_done) begin
                  if (DRAIN_CYCLES == 0) begin
                     state      <= StEnded;
                     programEnd <= 1'b1;
                     end_cause  <= 2'b01;
                  end else begin
                     state     <= StDrain;
                     drain_cnt <= 8'(DRAIN_CYCLES);
                  end
               end
`ifdef PROGRAM_END_WATCHDOG_EN
               else if (wd_hit) begin
                  state      <= StEnded;
                  programEnd <= 1'b1;
                  end_cause  <= 2'b10;
               end
`endif
            end
            StDrain: begin
               if (!cycle_sat) cycle_count <= cycle_count + CNT_W'(1);
               drain_cnt <= drain_cnt - 8'd1;
               if (drain_cnt == 8'd1) begin
                  state      <= StEnded;
                  programEnd <= 1'b1;
                  end_cause  <= 2'b01;
               end
            end
            StEnded: begin
               // Sticky until reset or clear; counters frozen.
            end
            default: state <= StRun;
         endcase
      end
   end

endmodule
